// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - variable-length instruction fetch unit (optional halt opcode via IFETCH_HALT_EN)
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_ce,
    output logic        mem_r,
    output logic [15:0] addr_bus,
    input  logic [7:0]  data_bus,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [15:0] instr_operand,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic        halted
);

    localparam logic [2:0] S_F0   = 3'd0;
    localparam logic [2:0] S_F1   = 3'd1;
    localparam logic [2:0] S_F2   = 3'd2;
    localparam logic [2:0] S_F3   = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
`ifdef IFETCH_HALT_EN
    localparam logic [2:0] S_HALT = 3'd5;
    localparam logic [7:0] HALT_OPCODE = 8'hFF;
`endif

    // Instruction length is carried entirely by the two top opcode bits.
    function automatic logic [1:0] decode_len(input logic [7:0] opc);
        logic [1:0] len;
        case (opc[7:6])
            2'b00:   len = 2'd1;
            2'b01:   len = 2'd2;
            default: len = 2'd3;
        endcase
        return len;
    endfunction

    logic [2:0]  state;
    logic [2:0]  state_d;
    logic [15:0] pc;
    logic [7:0]  op_q;
    logic [7:0]  lo_q;
    logic [1:0]  len_q;
    logic        accept;
    logic        load_out;
    logic [7:0]  out_opcode_d;
    logic [15:0] out_operand_d;
    logic [1:0]  out_len_d;

    // The presented instruction is consumed only if no redirect arrives in the same cycle.
    assign accept = (state == S_OUT) && instr_ready && !jmp;

    // Output registers are written only on the cycle that completes an instruction,
    // so an abandoned fetch never exposes a half-built instruction.
    assign load_out = (state_d == S_OUT) && (state != S_OUT);

    // Next-state selection; a redirect overrides whatever the sequencer wanted.
    always_comb begin
        state_d = state;
        case (state)
            S_F0:  state_d = S_F1;
            S_F1:  state_d = (decode_len(data_bus) == 2'd1) ? S_OUT : S_F2;
            S_F2:  state_d = (len_q == 2'd2) ? S_OUT : S_F3;
            S_F3:  state_d = S_OUT;
            S_OUT: begin
                if (instr_ready) begin
`ifdef IFETCH_HALT_EN
                    state_d = (instr_opcode == HALT_OPCODE) ? S_HALT : S_F0;
`else
                    state_d = S_F0;
`endif
                end
            end
`ifdef IFETCH_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_F0;
        endcase
        if (jmp) begin
            state_d = S_F0;
        end
    end

    // Assemble the instruction fields from the byte arriving this cycle plus the staged bytes.
    always_comb begin
        out_opcode_d  = op_q;
        out_operand_d = {data_bus, lo_q};
        out_len_d     = len_q;
        case (state)
            S_F1: begin
                out_opcode_d  = data_bus;
                out_operand_d = 16'h0000;
                out_len_d     = decode_len(data_bus);
            end
            S_F2: begin
                out_operand_d = {8'h00, data_bus};
            end
            default: begin
                out_operand_d = {data_bus, lo_q};
            end
        endcase
    end

    // Sequencer state and program counter; redirect beats a simultaneous accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_F0;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            if (jmp) begin
                pc <= jmp_addr;
            end else if (accept) begin
                pc <= pc + {14'd0, instr_len};
            end
        end
    end

    // Stage the opcode and first operand byte while the remaining bytes are still being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= 8'h00;
            lo_q  <= 8'h00;
            len_q <= 2'd0;
        end else begin
            if (state == S_F1) begin
                op_q  <= data_bus;
                len_q <= decode_len(data_bus);
            end
            if (state == S_F2) begin
                lo_q <= data_bus;
            end
        end
    end

    // Presented instruction fields; they change only when a new instruction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_opcode  <= 8'h00;
            instr_operand <= 16'h0000;
            instr_len     <= 2'd0;
            instr_pc      <= 16'h0000;
        end else if (load_out) begin
            instr_opcode  <= out_opcode_d;
            instr_operand <= out_operand_d;
            instr_len     <= out_len_d;
            instr_pc      <= pc;
        end
    end

    // Memory strobes: F1 and F2 read ahead of the decode so each byte lands one cycle later.
    always_comb begin
        mem_r    = !rst && ((state == S_F0) || (state == S_F1) || (state == S_F2));
        mem_ce   = mem_r;
        case (state)
            S_F1:    addr_bus = pc + 16'd1;
            S_F2:    addr_bus = pc + 16'd2;
            default: addr_bus = pc;
        endcase
    end

    assign instr_valid = (state == S_OUT);

`ifdef IFETCH_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        mem_ce, mem_r, mem_ce2, mem_r2;
    logic [15:0] addr_bus, addr_bus2;
    logic [7:0]  data_bus = 8'h00;
    logic [7:0]  data_bus2 = 8'h00;
    logic        jmp, jmp2;
    logic [15:0] jmp_addr, jmp_addr2;
    logic        instr_valid, instr_valid2;
    logic        instr_ready, instr_ready2;
    logic [7:0]  instr_opcode, instr_opcode2;
    logic [15:0] instr_operand, instr_operand2;
    logic [1:0]  instr_len, instr_len2;
    logic [15:0] instr_pc, instr_pc2;
    logic        halted, halted2;

    logic [7:0] mem  [0:65535];
    logic [7:0] mem2 [0:65535];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .mem_ce(mem_ce), .mem_r(mem_r), .addr_bus(addr_bus),
        .data_bus(data_bus), .jmp(jmp), .jmp_addr(jmp_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_operand(instr_operand),
        .instr_len(instr_len), .instr_pc(instr_pc), .halted(halted)
    );

    instr_fetch #(.RESET_PC(16'hFFFF)) u_dut2 (
        .clk(clk), .rst(rst2), .mem_ce(mem_ce2), .mem_r(mem_r2), .addr_bus(addr_bus2),
        .data_bus(data_bus2), .jmp(jmp2), .jmp_addr(jmp_addr2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2), .instr_opcode(instr_opcode2), .instr_operand(instr_operand2),
        .instr_len(instr_len2), .instr_pc(instr_pc2), .halted(halted2)
    );

    // Synchronous read memories: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (mem_r) data_bus <= mem[addr_bus];
        if (mem_r2) data_bus2 <= mem2[addr_bus2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!instr_valid && c < 20);
        chk("valid_timeout", 32'(instr_valid), 32'h1);
    endtask

    task automatic wait_valid2(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!instr_valid2 && c < 20);
        chk("valid2_timeout", 32'(instr_valid2), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 8'h00;
            mem2[i] = 8'h00;
        end
        mem[0] = 8'h05; mem[1] = 8'h45; mem[2] = 8'h12;
        mem[3] = 8'h80; mem[4] = 8'h34; mem[5] = 8'h12;
        mem2[16'hFFFF] = 8'h80; mem2[0] = 8'hCD; mem2[1] = 8'hAB;

        rst = 1'b1; rst2 = 1'b1;
        jmp = 1'b0; jmp2 = 1'b0; jmp_addr = 16'h0000; jmp_addr2 = 16'h0000;
        instr_ready = 1'b0; instr_ready2 = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_r", 32'(mem_r), 32'h0);
        chk("rst_mem_ce", 32'(mem_ce), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_opcode", 32'(instr_opcode), 32'h0);
        chk("rst_operand", 32'(instr_operand), 32'h0);
        chk("rst_len", 32'(instr_len), 32'h0);
        chk("rst_pc", 32'(instr_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst2_mem_r", 32'(mem_r2), 32'h0);

        // first read right after release, 1-byte latency of 2
        rst = 1'b0;
        #1;
        chk("first_read_r", 32'(mem_r), 32'h1);
        chk("first_read_ce", 32'(mem_ce), 32'h1);
        chk("first_read_addr", 32'(addr_bus), 32'h0000);
        @(negedge clk);
        chk("lat1_pre", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("lat1_valid", 32'(instr_valid), 32'h1);

        // back-pressure: hold for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(instr_valid), 32'h1);
            chk("hold_opcode", 32'(instr_opcode), 32'h05);
            chk("hold_no_read", 32'(mem_r), 32'h0);
            chk("hold_addr", 32'(addr_bus), 32'h0000);
        end
        chk("i0_operand", 32'(instr_operand), 32'h0000);
        chk("i0_len", 32'(instr_len), 32'h1);
        chk("i0_pc", 32'(instr_pc), 32'h0000);

        // stream the remaining two instructions
        instr_ready = 1'b1;
        wait_valid(cyc);
        chk("i1_cycles", 32'(cyc), 32'd4);
        chk("i1_opcode", 32'(instr_opcode), 32'h45);
        chk("i1_operand", 32'(instr_operand), 32'h0012);
        chk("i1_len", 32'(instr_len), 32'h2);
        chk("i1_pc", 32'(instr_pc), 32'h0001);
        wait_valid(cyc);
        chk("i2_cycles", 32'(cyc), 32'd5);
        chk("i2_opcode", 32'(instr_opcode), 32'h80);
        chk("i2_operand", 32'(instr_operand), 32'h1234);
        chk("i2_len", 32'(instr_len), 32'h3);
        chk("i2_pc", 32'(instr_pc), 32'h0003);

        // redirect back to 0001 while not accepting
        instr_ready = 1'b0;
        jmp = 1'b1; jmp_addr = 16'h0001;
        @(negedge clk);
        jmp = 1'b0;
        chk("jmp_kill_valid", 32'(instr_valid), 32'h0);
        chk("jmp_read_r", 32'(mem_r), 32'h1);
        chk("jmp_read_addr", 32'(addr_bus), 32'h0001);
        instr_ready = 1'b1;
        wait_valid(cyc);
        chk("j1_opcode", 32'(instr_opcode), 32'h45);
        chk("j1_pc", 32'(instr_pc), 32'h0001);

        // redirect coincident with accept of 45
        jmp = 1'b1; jmp_addr = 16'h0003;
        @(negedge clk);
        jmp = 1'b0;
        chk("jmpacc_valid", 32'(instr_valid), 32'h0);
        chk("jmpacc_addr", 32'(addr_bus), 32'h0003);
        wait_valid(cyc);
        chk("j2_opcode", 32'(instr_opcode), 32'h80);
        chk("j2_pc", 32'(instr_pc), 32'h0003);

        // reset in the middle of F2
        instr_ready = 1'b0;
        jmp = 1'b1; jmp_addr = 16'h0001;
        @(negedge clk);
        jmp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("f2_read_r", 32'(mem_r), 32'h1);
        chk("f2_read_addr", 32'(addr_bus), 32'h0003);
        rst = 1'b1;
        #1;
        chk("midrst_mem_r", 32'(mem_r), 32'h0);
        chk("midrst_opcode", 32'(instr_opcode), 32'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_valid", 32'(instr_valid), 32'h0);
        end

        // halt opcode at address 0
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h00;
        rst = 1'b0;
        #1;
        chk("rel_read_r", 32'(mem_r), 32'h1);
        chk("rel_read_addr", 32'(addr_bus), 32'h0000);
        wait_valid(cyc);
        chk("ff_opcode", 32'(instr_opcode), 32'hFF);
        chk("ff_operand", 32'(instr_operand), 32'h0000);
        chk("ff_len", 32'(instr_len), 32'h3);
        chk("ff_pc", 32'(instr_pc), 32'h0000);
        instr_ready = 1'b1;
        @(negedge clk);
`ifdef IFETCH_HALT_EN
        chk("halt_enter", 32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_no_read", 32'(mem_r), 32'h0);
            chk("halt_held", 32'(halted), 32'h1);
        end
        jmp = 1'b1; jmp_addr = 16'h0003;
        @(negedge clk);
        jmp = 1'b0;
        chk("halt_exit", 32'(halted), 32'h0);
        chk("halt_exit_r", 32'(mem_r), 32'h1);
        chk("halt_exit_addr", 32'(addr_bus), 32'h0003);
`else
        chk("ff_not_halted", 32'(halted), 32'h0);
        chk("ff_next_r", 32'(mem_r), 32'h1);
        chk("ff_next_addr", 32'(addr_bus), 32'h0003);
`endif

        // address wrap from RESET_PC = FFFF
        instr_ready2 = 1'b1;
        rst2 = 1'b0;
        #1;
        chk("w_first_r", 32'(mem_r2), 32'h1);
        chk("w_first_addr", 32'(addr_bus2), 32'hFFFF);
        wait_valid2(cyc);
        chk("w_opcode", 32'(instr_opcode2), 32'h80);
        chk("w_operand", 32'(instr_operand2), 32'hABCD);
        chk("w_len", 32'(instr_len2), 32'h3);
        chk("w_pc", 32'(instr_pc2), 32'hFFFF);
        @(negedge clk);
        chk("w_next_r", 32'(mem_r2), 32'h1);
        chk("w_next_addr", 32'(addr_bus2), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_ce  output  1  memory chip enable, asserted together with mem_r.
REQ-005 SHALL have port mem_r  output  1  memory read strobe.
REQ-006 SHALL have port addr_bus  output  16  byte address of the current read.
REQ-007 SHALL have port data_bus  input  8  read data, valid one cycle after the mem_r cycle.
REQ-008 SHALL have port jmp  input  1  redirect request, single-cycle pulse.
REQ-009 SHALL have port jmp_addr  input  16  redirect target.
REQ-010 SHALL have port instr_valid  output  1  assembled instruction available to the control unit.
REQ-011 SHALL have port instr_ready  input  1  control unit accepts the instruction.
REQ-012 SHALL have port instr_opcode  output  8  opcode byte.
REQ-013 SHALL have port instr_operand  output  16  {byte2, byte1}; unused bytes zero.
REQ-014 SHALL have port instr_len  output  2  instruction length, 1 to 3.
REQ-015 SHALL have port instr_pc  output  16  address of the opcode byte.
REQ-016 SHALL have port halted  output  1  fetch stopped on a halt opcode.

Function
REQ-017 SHALL decode length from opcode[7:6]: 00 gives 1 byte, 01 gives 2 bytes, 1x gives 3 bytes.
REQ-018 SHALL implement states F0, F1, F2, F3, OUT, and HALT (HALT only with the macro in REQ-032).
REQ-019 F0: mem_r=1, addr=pc; next state is F1.
REQ-020 F1: mem_r=1, addr=pc+1 (speculative read); capture opcode from data_bus; next state is OUT if len=1, else F2.
REQ-021 F2: mem_r=1, addr=pc+2; capture operand[7:0]; next state is OUT if len=2, else F3.
REQ-022 F3: mem_r=0; capture operand[15:8]; next state is OUT.
REQ-023 OUT: instr_valid=1 and mem_r=0.
- On instr_valid and instr_ready: pc <= pc+len, instr_valid falls, next state is F0.
- Outputs SHALL remain stable while instr_ready=0.
REQ-024 Latency SHALL be F0-entry to instr_valid of 2, 3 or 4 cycles for len 1, 2 or 3; back-to-back 1-byte throughput is one instruction per 3 cycles.
REQ-025 All address arithmetic SHALL be modulo 2^16; reads past 16'hFFFF wrap to 16'h0000.
REQ-026 jmp SHALL be honoured in any state:
- pc <= jmp_addr, next state F0, instr_valid=0 on the next cycle.
- jmp has priority over a simultaneous accept; the accepted instruction is discarded and pc does not advance by len.
REQ-027 SHALL hold mem_ce equal to mem_r at all times.

Reset
REQ-028 While rst=1: state=F0, pc=RESET_PC, mem_ce=mem_r=0, instr_valid=0, instr_opcode=0, instr_operand=0, instr_len=0, instr_pc=0, halted=0.
REQ-029 The first read (addr=RESET_PC) SHALL be issued in the first cycle after rst deasserts.
REQ-030 rst asserted mid-fetch or in OUT SHALL abandon the instruction immediately, with no partial output.
REQ-031 rst SHALL take priority over jmp.

Configuration
REQ-032 With macro IFETCH_HALT_EN defined:
- Opcode 8'hFF (3-byte class) is fetched and presented normally.
- On its acceptance the unit enters HALT: mem_r=0, halted=1, no further reads.
- HALT is exited only by jmp (next state F0, halted=0) or rst.
REQ-033 Without IFETCH_HALT_EN: 8'hFF is an ordinary 3-byte opcode, HALT does not exist, and halted is tied 0.

Verification
REQ-034 Memory [0]=05 [1]=45 [2]=12 [3]=80 [4]=34 [5]=12, ready=1 -> outputs in order:
- (05, 0000, len 1, pc 0000)
- (45, 0012, len 2, pc 0001)
- (80, 1234, len 3, pc 0003)
REQ-035 Same memory with instr_ready=0 for 5 cycles on the first instruction -> instr_valid and opcode 05 held stable, no reads, pc stays 0000.
REQ-036 jmp=1, jmp_addr=0003, asserted in the same cycle as the accept of opcode 45 -> next instruction is 80 at pc 0003; opcode 45 is not repeated.
REQ-037 RESET_PC=FFFF, memory [FFFF]=80 [0000]=CD [0001]=AB -> opcode 80, operand ABCD, pc FFFF; next fetch starts at 0002.
REQ-038 IFETCH_HALT_EN, memory [0]=FF [1]=00 [2]=00 -> FF presented and accepted, then halted=1 and mem_r stays 0 for 10 cycles; jmp to 0003 -> halted=0 and a read at 0003.
REQ-039 rst pulsed during F2 -> instr_valid stays 0, and the first read after release is at RESET_PC.
